comparator_arbiter: RTL and testbench
=====================================

# comparator_arbiter

Shares one signed less-than comparator (`comparator_lt`, two's-complement) between `R` requesters. Requests are granted round-robin over a valid/ready handshake. Each accepted request produces one response on a single shared response channel, tagged with the requester index. The block sits between the datapath units that need signed compares and the single comparator instance it owns.

## Interface
- `N`, 32, operand width in bits; operands are two's-complement.
- `R`, 4, number of requesters; `R >= 2`.
- `IW`, `$clog2(R)`, width of the requester index.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `R`  bit `i` set: requester `i` presents an operand pair.
- `req_a`  in  `R*N`  packed operand A; requester `i` at bits `[i*N +: N]`.
- `req_b`  in  `R*N`  packed operand B; same packing as `req_a`.
- `req_ready`  out  `R`  one-hot or zero; bit `i` set means requester `i` is accepted this cycle.
- `rsp_valid`  out  1  response present.
- `rsp_id`  out  `IW`  index of the requester the response belongs to.
- `rsp_lt`  out  1  1 if `$signed(a) < $signed(b)`, else 0.
- `rsp_ready`  in  1  consumer accepts the response.

## Operation
- The FSM has three states: IDLE, COMPARE, RESPOND.
- **IDLE**
  - If any `req_valid` is set, grant `g` is the first set bit searching upward (with wrap) from `last_grant+1`.
  - `req_ready[g]` is driven combinationally in this state only; all other bits are 0.
  - At the clock edge:
    - capture `req_a[g]` into `op_a` and `req_b[g]` into `op_b`;
    - set `cur_id <= g` and `last_grant <= g`;
    - go to COMPARE.
  - If no `req_valid` bit is set, stay in IDLE with `req_ready = 0`.
- **COMPARE**
  - The internal `comparator_lt #(.N(N))` evaluates the registered `op_a`, `op_b`.
  - At the edge: `rsp_lt <= out`, `rsp_id <= cur_id`, `rsp_valid <= 1`; go to RESPOND.
  - `req_ready = 0`.
- **RESPOND**
  - Hold `rsp_valid`, `rsp_id` and `rsp_lt` stable until `rsp_ready` is set.
  - On the cycle where `rsp_valid && rsp_ready`: `rsp_valid <= 0`, go to IDLE.
  - `req_ready = 0` throughout.
- Handshake rules:
  - A request is accepted only on a cycle where `req_valid[i] && req_ready[i]`.
  - A requester holds its valid and operands until accepted. The block never samples operands outside the acceptance cycle.
  - Deasserting `req_valid[i]` before acceptance withdraws the request and causes no error.
- Compare is signed and full width:
  - `a == b` gives 0.
  - `0x80000000 < 0x7FFFFFFF` gives 1 at `N=32`.
  - Extreme-operand overflow must not flip the result.
- Fairness: under continuous contention, every requester is served once per `R` grants. No requester waits more than `R-1` other grants.

## Timing
- Reset values:
  - state = IDLE;
  - `last_grant = R-1`, so requester 0 has first priority;
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_lt = 0`;
  - `op_a = op_b = 0`, `cur_id = 0`.
- `req_ready` is forced to 0 while `rst` is high.
- Latency: acceptance at edge `t`, then `rsp_valid` is high after edge `t+1`.
- Throughput:
  - Minimum request-to-request spacing is 3 cycles (accept, compare, respond with `rsp_ready` already high).
  - Each cycle of response backpressure adds one cycle.
- Reset mid-operation: any captured request or pending response is discarded. `rsp_valid` is 0 the cycle after the reset edge, and the round-robin pointer returns to `last_grant = R-1`.
- `rsp_ready` held high continuously: the response is visible for exactly one cycle.
- `req_valid` high in the same cycle the FSM returns to IDLE: the grant is evaluated in IDLE on the following cycle, never during RESPOND.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req_valid = 1` -> `req_ready = 0` and `rsp_valid = 0` throughout; first grant after release goes to requester 0.
- **Single request:** requester 2 sends `a = -5` (`0xFFFFFFFB`), `b = 3`, `rsp_ready = 1` -> `req_ready[2]` at cycle 0; `rsp_valid = 1`, `rsp_id = 2`, `rsp_lt = 1` at cycle 2; ready for a new grant at cycle 3.
- **Signed extremes and equality:** `(0x80000000, 0x7FFFFFFF)` -> 1; `(0x7FFFFFFF, 0x80000000)` -> 0; `(7, 7)` -> 0; `(0xFFFFFFFF, 0)` -> 1.
- **Round-robin fairness:** all 4 requesters valid continuously, each with distinct operands -> grant order 0,1,2,3,0,1; every `rsp_id`/`rsp_lt` pair matches that requester's operands.
- **Backpressure and reset mid-operation:**
  - Hold `rsp_ready = 0` for 5 cycles in RESPOND -> `rsp_*` stable and no `req_ready`; the response completes when `rsp_ready` rises.
  - Repeat, but assert `rst` during COMPARE -> no response emitted, and the next grant goes to requester 0.

Source files
------------

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter that time-shares one signed less-than comparator among
// R requesters; each accepted request yields one tagged response.

module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   assign lt = $signed(a) < $signed(b);
endmodule

// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for any req_valid; grants round-robin and captures ops
// S_COMPARE | comparator evaluates registered operands; result registered
// S_RESPOND | rsp_valid held until rsp_ready
module comparator_arbiter #(
   parameter int N  = 32,
   parameter int R  = 4,
   parameter int IW = $clog2(R)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [R-1:0]   req_valid,
   input  logic [R*N-1:0] req_a,
   input  logic [R*N-1:0] req_b,
   output logic [R-1:0]   req_ready,
   output logic           rsp_valid,
   output logic [IW-1:0]  rsp_id,
   output logic           rsp_lt,
   input  logic           rsp_ready
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t        state_q,      state_d;
   logic [IW-1:0] last_grant_q, last_grant_d;
   logic [IW-1:0] cur_id_q,     cur_id_d;
   logic [N-1:0]  op_a_q,       op_a_d;
   logic [N-1:0]  op_b_q,       op_b_d;
   logic          rsp_valid_q,  rsp_valid_d;
   logic [IW-1:0] rsp_id_q,     rsp_id_d;
   logic          rsp_lt_q,     rsp_lt_d;

   logic          gnt_found;
   logic [IW-1:0] gnt_idx;
   logic          cmp_lt;

   comparator_lt #(.N(N)) u_cmp (
      .a  (op_a_q),
      .b  (op_b_q),
      .lt (cmp_lt)
   );

   // Search upward from the requester after the last grant, wrapping at R.
   always_comb begin
      int probe;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      probe     = 0;
      for (int k = 1; k <= R; k++) begin
         probe = (int'(last_grant_q) + k) % R;
         if (!gnt_found && req_valid[probe]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(probe);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_lt_d     = rsp_lt_q;
      req_ready    = '0;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               req_ready[gnt_idx] = 1'b1;
               op_a_d             = req_a[gnt_idx*N +: N];
               op_b_d             = req_b[gnt_idx*N +: N];
               cur_id_d           = gnt_idx;
               last_grant_d       = gnt_idx;
               state_d            = S_COMPARE;
            end
         end
         S_COMPARE: begin
            rsp_lt_d    = cmp_lt;
            rsp_id_d    = cur_id_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESPOND;
         end
         S_RESPOND: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) req_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= IW'(R-1);
         cur_id_q     <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_lt_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_lt_q     <= rsp_lt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_lt    = rsp_lt_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed and randomized bench for comparator_arbiter, checked every cycle
// against a transaction-level reference model.

module tb_comparator_arbiter;
   localparam int N  = 32;
   localparam int R  = 4;
   localparam int IW = $clog2(R);

   logic           clk;
   logic           rst;
   logic [R-1:0]   req_valid;
   logic [R*N-1:0] req_a;
   logic [R*N-1:0] req_b;
   logic [R-1:0]   req_ready;
   logic           rsp_valid;
   logic [IW-1:0]  rsp_id;
   logic           rsp_lt;
   logic           rsp_ready;

   comparator_arbiter #(.N(N), .R(R), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_lt    (rsp_lt),
      .rsp_ready (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: phase 0 = free to grant, 1 = one cycle after
   // acceptance, 2 = response outstanding.
   int            m_phase;
   int            m_ptr;
   logic [N-1:0]  m_a, m_b;
   int            m_id;
   logic          m_rv;
   logic [IW-1:0] m_rid;
   logic          m_rlt;

   logic          auto_drop;
   logic [R-1:0]  obs_ready;
   logic          obs_rv;
   logic [IW-1:0] obs_id;
   logic          obs_lt;

   // Signed order via offset-binary: flipping the sign bit maps
   // two's-complement order onto unsigned order.
   function automatic logic ref_lt(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] sb;
      sb = {1'b1, {(N-1){1'b0}}};
      return (a ^ sb) < (b ^ sb);
   endfunction

   function automatic logic [R-1:0] exp_ready();
      logic [R-1:0] r;
      r = '0;
      if (rst || m_phase != 0) return r;
      for (int k = 1; k <= R; k++) begin
         int idx;
         idx = (m_ptr + k) % R;
         if (req_valid[idx]) begin
            r[idx] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_ptr   = R - 1;
      m_rv    = 1'b0;
      m_rid   = '0;
      m_rlt   = 1'b0;
      m_id    = 0;
      m_a     = '0;
      m_b     = '0;
   endtask

   task automatic model_update(input logic [R-1:0] er);
      if (rst) begin
         model_reset();
      end else if (m_phase == 0) begin
         for (int i = 0; i < R; i++) begin
            if (er[i]) begin
               m_ptr   = i;
               m_id    = i;
               m_a     = req_a[i*N +: N];
               m_b     = req_b[i*N +: N];
               m_phase = 1;
            end
         end
      end else if (m_phase == 1) begin
         m_rv    = 1'b1;
         m_rid   = IW'(m_id);
         m_rlt   = ref_lt(m_a, m_b);
         m_phase = 2;
      end else if (rsp_ready) begin
         m_rv    = 1'b0;
         m_phase = 0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model at
   // the rising edge, then let requesters drop granted requests.
   task automatic cycle();
      logic [R-1:0] er;
      er = exp_ready();
      @(negedge clk);
      obs_ready = req_ready;
      obs_rv    = rsp_valid;
      obs_id    = rsp_id;
      obs_lt    = rsp_lt;
      check("req_ready", 32'(req_ready), 32'(er));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
         check("rsp_id", 32'(rsp_id), 32'(m_rid));
         check("rsp_lt", 32'(rsp_lt), 32'(m_rlt));
      end
      @(posedge clk);
      model_update(er);
      #1;
      if (auto_drop) req_valid = req_valid & ~er;
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!obs_rv && n < 10);
      check(tag, 32'(obs_rv), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      auto_drop = 1'b1;
      repeat (4) cycle();
   endtask

   initial begin
      logic [N-1:0] pa [4];
      logic [N-1:0] pb [4];
      logic         pe [4];
      int           order [6];
      int           grants [$];

      rst       = 1'b1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      auto_drop = 1'b1;
      @(posedge clk);
      #1;
      model_reset();

      // reset held with every requester asserting valid
      repeat (2) begin
         cycle();
         check("rst_ready", 32'(obs_ready), 32'd0);
         check("rst_rsp_valid", 32'(obs_rv), 32'd0);
      end
      rst = 1'b0;
      cycle();
      check("first_grant", 32'(obs_ready), 32'b0001);
      drain();

      // single request from requester 2: -5 < 3
      do_reset();
      req_a[2*N +: N] = 32'hFFFF_FFFB;
      req_b[2*N +: N] = 32'd3;
      req_valid       = 4'b0100;
      cycle();
      check("single_ready", 32'(obs_ready), 32'b0100);
      cycle();
      check("single_cmp_rv", 32'(obs_rv), 32'd0);
      cycle();
      check("single_rv", 32'(obs_rv), 32'd1);
      check("single_id", 32'(obs_id), 32'd2);
      check("single_lt", 32'(obs_lt), 32'd1);
      req_valid = 4'b0100;
      cycle();
      check("single_regrant", 32'(obs_ready), 32'b0100);
      drain();

      // signed extremes and equality
      pa[0] = 32'h8000_0000; pb[0] = 32'h7FFF_FFFF; pe[0] = 1'b1;
      pa[1] = 32'h7FFF_FFFF; pb[1] = 32'h8000_0000; pe[1] = 1'b0;
      pa[2] = 32'd7;         pb[2] = 32'd7;         pe[2] = 1'b0;
      pa[3] = 32'hFFFF_FFFF; pb[3] = 32'd0;         pe[3] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         req_a[j*N +: N] = pa[j];
         req_b[j*N +: N] = pb[j];
         req_valid       = '0;
         req_valid[j]    = 1'b1;
         wait_rsp("extreme_rsp");
         check("extreme_id", 32'(obs_id), 32'(j));
         check("extreme_lt", 32'(obs_lt), 32'(pe[j]));
         drain();
      end

      // fairness under continuous contention
      do_reset();
      req_a[0*N +: N] = -32'sd100; req_b[0*N +: N] = 32'd3;
      req_a[1*N +: N] = 32'd50;    req_b[1*N +: N] = -32'sd2;
      req_a[2*N +: N] = 32'd7;     req_b[2*N +: N] = 32'd7;
      req_a[3*N +: N] = 32'h8000_0000; req_b[3*N +: N] = 32'd5;
      req_valid = 4'b1111;
      auto_drop = 1'b0;
      rsp_ready = 1'b1;
      repeat (18) begin
         cycle();
         for (int i = 0; i < R; i++)
            if (obs_ready[i]) grants.push_back(i);
      end
      order = '{0, 1, 2, 3, 0, 1};
      check("rr_count", 32'(grants.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < grants.size()) check("rr_order", 32'(grants[i]), 32'(order[i]));
      drain();

      // response backpressure for five cycles
      do_reset();
      req_a[1*N +: N] = 32'd1;
      req_b[1*N +: N] = 32'd2;
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      wait_rsp("bp_rsp");
      req_valid = 4'b1111;
      repeat (4) begin
         cycle();
         check("bp_hold_rv", 32'(obs_rv), 32'd1);
         check("bp_hold_id", 32'(obs_id), 32'd1);
         check("bp_hold_lt", 32'(obs_lt), 32'd1);
         check("bp_no_ready", 32'(obs_ready), 32'd0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      cycle();
      check("bp_release_rv", 32'(obs_rv), 32'd1);
      cycle();
      check("bp_done_rv", 32'(obs_rv), 32'd0);
      drain();

      // reset while comparing discards the request
      do_reset();
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      cycle();
      check("rm_accept", 32'(obs_ready), 32'b0100);
      rst = 1'b1;
      cycle();
      check("rm_rv_in_rst", 32'(obs_rv), 32'd0);
      rst       = 1'b0;
      req_valid = 4'b1111;
      cycle();
      check("rm_regrant", 32'(obs_ready), 32'b0001);
      check("rm_rv_after", 32'(obs_rv), 32'd0);
      drain();

      // randomized traffic, backpressure, withdrawals and resets
      auto_drop = 1'b1;
      for (int t = 0; t < 500; t++) begin
         rst = ($urandom_range(0, 79) == 0);
         for (int i = 0; i < R; i++) begin
            if (req_valid[i]) begin
               if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req_a[i*N +: N] = rand_op();
               req_b[i*N +: N] = rand_op();
               req_valid[i]    = 1'b1;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rst = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
